// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_W = 8;

  localparam logic [PC_W-1:0] RESET_PC  = PC_W'(0);
  localparam logic [XLEN-1:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [XLEN-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_zext(input logic [PC_W-1:0] pc);
    return {{(XLEN-PC_W){1'b0}}, pc};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: reset, load, hold and modulo-2**PC_W increment.
module fetch_stage_pc_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Load wins over increment; neither means hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the fetched word into IF/ID,
// and handles stall, redirect, halt and the delivered-instruction counter.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_out,
  input  logic [XLEN-1:0] instr_in,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            halted,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [XLEN-1:0] if_id_instr_q;
  logic [PC_W-1:0] if_id_pc_q;
  logic            if_id_valid_q;
  logic [XLEN-1:0] fetch_count_q;

  logic            is_halt_c;
  logic            fetch_en_c;
  logic            pc_inc_c;
  logic            unused_redirect_hi_c;

  assign is_halt_c  = (instr_in == HALT_WORD);
  assign fetch_en_c = !redirect && (state_q == ST_RUN) && !stall;
  // A fetched halt word is delivered but the PC stays on it.
  assign pc_inc_c   = fetch_en_c && !is_halt_c;

  assign unused_redirect_hi_c = ^redirect_pc[XLEN-1:PC_W];

  fetch_stage_pc_reg u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (redirect),
    .load_val_i (redirect_pc[PC_W-1:0]),
    .inc_i      (pc_inc_c),
    .pc_o       (pc_q)
  );

  // FSM, IF/ID register and counter; priority reset > redirect > halted > stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      if_id_instr_q <= NOP_WORD;
      if_id_pc_q    <= PC_W'(0);
      if_id_valid_q <= 1'b0;
      fetch_count_q <= XLEN'(0);
    end else if (redirect) begin
      state_q       <= ST_RUN;
      if_id_instr_q <= NOP_WORD;
      if_id_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HALTED: begin
          if_id_instr_q <= NOP_WORD;
          if_id_valid_q <= 1'b0;
        end
        default: begin
          if (!stall) begin
            if_id_instr_q <= instr_in;
            if_id_pc_q    <= pc_q;
            if_id_valid_q <= 1'b1;
            fetch_count_q <= fetch_count_q + XLEN'(1);
            if (is_halt_c) begin
              state_q <= ST_HALTED;
            end
          end
        end
      endcase
    end
  end

  assign pc_out      = pc_zext(pc_q);
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = pc_zext(if_id_pc_q);
  assign if_id_valid = if_id_valid_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed vectors push expected post-edge
// state; an independent monitor pops and compares after every rising edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] DC   = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;
    logic        halted;
    logic [31:0] count;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];
  exp_t        sb_q[$];
  int          n_vec;
  int          n_err;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_out      (pc_out),
    .instr_in    (instr_in),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  assign instr_in = mem[pc_out[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next edge and record what that edge must produce.
  task automatic vec(input logic rst, input logic stl, input logic rdr,
                     input logic [31:0] rpc, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input logic [31:0] e_ipc,
                     input logic e_valid, input logic e_halt,
                     input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst_n       = ~rst;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    e.pc = e_pc; e.instr = e_instr; e.ipc = e_ipc;
    e.valid = e_valid; e.halted = e_halt; e.count = e_cnt;
    sb_q.push_back(e);
  endtask

  // Monitor: every edge that has a pending expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (pc_out !== e.pc || if_id_instr !== e.instr ||
            (e.ipc !== DC && if_id_pc !== e.ipc) ||
            if_id_valid !== e.valid || halted !== e.halted ||
            fetch_count !== e.count) begin
          n_err++;
          $display("FAIL vec%0d: got pc=%h instr=%h ipc=%h v=%b h=%b cnt=%0d exp pc=%h instr=%h ipc=%h v=%b h=%b cnt=%0d",
                   n_vec - 1, pc_out, if_id_instr, if_id_pc, if_id_valid, halted,
                   fetch_count, e.pc, e.instr, e.ipc, e.valid, e.halted, e.count);
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[5] = HALT;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    //   rst stl rdr rpc          pc        instr         ipc       v  h  cnt
    vec(1, 0, 0, 0,            32'h00, NOP,          32'h00, 0, 0, 0);   // reset
    vec(0, 0, 0, 0,            32'h01, 32'h11,       32'h00, 1, 0, 1);
    vec(0, 0, 0, 0,            32'h02, 32'h22,       32'h01, 1, 0, 2);
    vec(0, 1, 0, 0,            32'h02, 32'h22,       32'h01, 1, 0, 2);   // stall
    vec(0, 1, 0, 0,            32'h02, 32'h22,       32'h01, 1, 0, 2);
    vec(0, 0, 0, 0,            32'h03, 32'h33,       32'h02, 1, 0, 3);   // release
    vec(0, 0, 0, 0,            32'h04, 32'h44,       32'h03, 1, 0, 4);
    vec(0, 0, 0, 0,            32'h05, 32'hA0000004, 32'h04, 1, 0, 5);
    vec(0, 0, 0, 0,            32'h05, HALT,         32'h05, 1, 1, 6);   // halt delivered
    vec(0, 1, 0, 0,            32'h05, NOP,          DC,     0, 1, 6);
    vec(0, 0, 0, 0,            32'h05, NOP,          DC,     0, 1, 6);
    vec(0, 1, 0, 0,            32'h05, NOP,          DC,     0, 1, 6);
    vec(0, 0, 1, 0,            32'h00, NOP,          DC,     0, 0, 6);   // exit halt
    vec(0, 0, 0, 0,            32'h01, 32'h11,       32'h00, 1, 0, 7);
    vec(0, 0, 0, 0,            32'h02, 32'h22,       32'h01, 1, 0, 8);
    vec(0, 1, 1, 32'h140,      32'h40, NOP,          DC,     0, 0, 8);   // redirect+stall
    vec(0, 0, 0, 0,            32'h41, 32'hA0000040, 32'h40, 1, 0, 9);
    vec(0, 0, 1, 32'hFE,       32'hFE, NOP,          DC,     0, 0, 9);   // wrap
    vec(0, 0, 0, 0,            32'hFF, 32'hA00000FE, 32'hFE, 1, 0, 10);
    vec(0, 0, 0, 0,            32'h00, 32'hA00000FF, 32'hFF, 1, 0, 11);
    vec(0, 0, 0, 0,            32'h01, 32'h11,       32'h00, 1, 0, 12);
    vec(0, 0, 0, 0,            32'h02, 32'h22,       32'h01, 1, 0, 13);
    vec(1, 1, 0, 0,            32'h00, NOP,          32'h00, 0, 0, 0);   // reset mid-run
    vec(0, 0, 0, 0,            32'h01, 32'h11,       32'h00, 1, 0, 1);
    vec(0, 0, 1, 32'h05,       32'h05, NOP,          DC,     0, 0, 1);
    vec(0, 0, 0, 0,            32'h05, HALT,         32'h05, 1, 1, 2);
    vec(1, 0, 0, 0,            32'h00, NOP,          32'h00, 0, 0, 0);   // reset mid-halt
    vec(0, 0, 0, 0,            32'h01, 32'h11,       32'h00, 1, 0, 1);

    repeat (4) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
